// File: rtl/exhaustive_tester_pkg.sv
// Shared types and helpers for the exhaustive vector tester.
package exhaustive_tester_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } tester_state_t;

   function automatic int vec_count(input int n_in);
      return 1 << n_in;
   endfunction

endpackage

// File: rtl/exhaustive_vector_tester_settle_timer.sv
// Loadable down-counter that sets the per-vector settle window.
module settle_timer #(
   parameter int SETTLE_CYC = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic zero
);

   localparam int W = $clog2(SETTLE_CYC) + 1;
   localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYC - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= LOAD_VAL;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/exhaustive_vector_tester.sv
// Sweeps a small combinational block through every input vector and scores
// its responses against a truth table.
//
// state  | meaning
// IDLE   | waiting for start, results cleared by reset
// SETTLE | current vector applied, waiting for the block to settle
// CHECK  | sample dut_out, score the vector, advance or finish
// DONE   | sweep finished, results held until the next start
module exhaustive_vector_tester
   import exhaustive_tester_pkg::*;
#(
   parameter int                     N_IN       = 3,
   parameter logic [(2**N_IN)-1:0]   EXPECTED   = 8'h31,
   parameter int                     SETTLE_CYC = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            fail_valid,
   output logic [N_IN-1:0] fail_vec
);

   localparam int              N_VEC    = vec_count(N_IN);
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'(N_VEC - 1);

   tester_state_t   state_q;
   logic [N_IN-1:0] vec_q;
   logic [N_IN:0]   err_q;
   logic [N_IN:0]   err_d;
   logic            fail_valid_q;
   logic [N_IN-1:0] fail_vec_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;

   logic mismatch;
   logic start_ok;
   logic last_vec;
   logic tmr_load;
   logic tmr_en;
   logic tmr_zero;

   always_comb begin
      mismatch = dut_out ^ EXPECTED[vec_q];
      err_d    = err_q + {{N_IN{1'b0}}, mismatch};
      start_ok = start && ((state_q == IDLE) || (state_q == DONE));
      last_vec = (vec_q == LAST_VEC);
      tmr_load = start_ok || ((state_q == CHECK) && !last_vec);
      tmr_en   = (state_q == SETTLE);
   end

   settle_timer #(
      .SETTLE_CYC (SETTLE_CYC)
   ) u_settle_timer (
      .clk   (clk),
      .reset (reset),
      .load  (tmr_load),
      .en    (tmr_en),
      .zero  (tmr_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         vec_q        <= '0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_ok) begin
                  err_q        <= '0;
                  fail_valid_q <= 1'b0;
                  fail_vec_q   <= '0;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  vec_q        <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= SETTLE;
               end
            end
            SETTLE: begin
               if (tmr_zero) begin
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               err_q <= err_d;
               if (mismatch && !fail_valid_q) begin
                  fail_vec_q   <= vec_q;
                  fail_valid_q <= 1'b1;
               end
               // Terminate on compare so vec never wraps back to 0.
               if (last_vec) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == '0);
                  state_q <= DONE;
               end else begin
                  vec_q   <= vec_q + N_IN'(1);
                  state_q <= SETTLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign dut_in     = vec_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fail_valid_q;
   assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_exhaustive_vector_tester.sv
// Scoreboard bench: stimulus pushes expected sweep results, monitors pop on done.
module tb_exhaustive_vector_tester;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance 1: default parameters.
   logic       rst, start;
   logic [2:0] dut_in;
   logic       dut_out;
   logic       busy, done, pass;
   logic [3:0] err_count;
   logic       fail_valid;
   logic [2:0] fail_vec;

   // Instance 2: N_IN=2, SETTLE_CYC=1, AND-gate truth table.
   logic       rst2, start2;
   logic [1:0] dut_in2;
   logic       dut_out2;
   logic       busy2, done2, pass2;
   logic [2:0] err_count2;
   logic       fail_valid2;
   logic [1:0] fail_vec2;

   int mode = 0;

   function automatic logic golden(input logic [2:0] v);
      return (~v[1] & ~v[0]) | (v[2] & ~v[1] & v[0]);
   endfunction

   always_comb begin
      dut_out = 1'b0;
      case (mode)
         0:       dut_out = golden(dut_in);
         1:       dut_out = golden(dut_in) ^ (dut_in == 3'd3);
         default: dut_out = 1'b0;
      endcase
   end

   assign dut_out2 = &dut_in2;

   exhaustive_vector_tester dut (
      .clk        (clk),
      .reset      (rst),
      .start      (start),
      .dut_in     (dut_in),
      .dut_out    (dut_out),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .fail_valid (fail_valid),
      .fail_vec   (fail_vec)
   );

   exhaustive_vector_tester #(
      .N_IN       (2),
      .EXPECTED   (4'b1000),
      .SETTLE_CYC (1)
   ) dut2 (
      .clk        (clk),
      .reset      (rst2),
      .start      (start2),
      .dut_in     (dut_in2),
      .dut_out    (dut_out2),
      .busy       (busy2),
      .done       (done2),
      .pass       (pass2),
      .err_count  (err_count2),
      .fail_valid (fail_valid2),
      .fail_vec   (fail_vec2)
   );

   typedef struct {
      logic [3:0] err;
      logic       fv;
      logic [2:0] fvec;
      logic       pass;
      int         done_edge;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input int err, input bit fv, input int fvec, input bit p);
      exp_t e;
      e.err       = 4'(err);
      e.fv        = fv;
      e.fvec      = 3'(fvec);
      e.pass      = p;
      e.done_edge = 0;
      return e;
   endfunction

   logic done_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (done && !done_prev) begin
         if (q1.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            check("err_count",  32'(err_count),  32'(e.err));
            check("fail_valid", 32'(fail_valid), 32'(e.fv));
            check("fail_vec",   32'(fail_vec),   32'(e.fvec));
            check("pass",       32'(pass),       32'(e.pass));
            check("busy_at_done", 32'(busy),     32'd0);
            check("done_edge",  32'(cyc),        32'(e.done_edge));
         end
      end
      done_prev = done;
   end

   logic done2_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (done2 && !done2_prev) begin
         if (q2.size() == 0) begin
            check("unexpected_done2", 32'd1, 32'd0);
         end else begin
            e = q2.pop_front();
            check("err_count2",  32'(err_count2),  32'(e.err));
            check("fail_valid2", 32'(fail_valid2), 32'(e.fv));
            check("pass2",       32'(pass2),       32'(e.pass));
            check("done_edge2",  32'(cyc),         32'(e.done_edge));
         end
      end
      done2_prev = done2;
   end

   // Returns at the negedge following the edge that sampled start.
   task automatic issue(input exp_t e, input bit push);
      exp_t x;
      x = e;
      @(negedge clk);
      start = 1'b1;
      x.done_edge = cyc + 1 + 24;
      if (push) q1.push_back(x);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && !done; i++) @(negedge clk);
      if (!done) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dut_in"},     32'(dut_in),     32'd0);
      check({tag, "_busy"},       32'(busy),       32'd0);
      check({tag, "_done"},       32'(done),       32'd0);
      check({tag, "_pass"},       32'(pass),       32'd0);
      check({tag, "_err_count"},  32'(err_count),  32'd0);
      check({tag, "_fail_valid"}, 32'(fail_valid), 32'd0);
      check({tag, "_fail_vec"},   32'(fail_vec),   32'd0);
   endtask

   initial begin
      exp_t e2;
      rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      check("reset_busy2", 32'(busy2), 32'd0);
      check("reset_done2", 32'(done2), 32'd0);
      rst = 1'b0; rst2 = 1'b0;
      repeat (2) @(negedge clk);

      // Golden block: watch each vector held for 3 cycles.
      mode = 0;
      issue(mk(0, 0, 0, 1), 1'b1);
      for (int k = 0; k <= 24; k++) begin
         check($sformatf("dut_in_k%0d", k), 32'(dut_in), (k / 3 > 7) ? 32'd7 : 32'(k / 3));
         check($sformatf("busy_k%0d", k), 32'(busy), (k < 24) ? 32'd1 : 32'd0);
         if (k < 24) @(negedge clk);
      end
      wait_done();
      repeat (3) @(negedge clk);
      check("done_hold", 32'(done), 32'd1);
      check("dut_in_hold", 32'(dut_in), 32'd7);

      mode = 1;
      issue(mk(1, 1, 3, 0), 1'b1);
      wait_done();
      repeat (2) @(negedge clk);

      mode = 2;
      issue(mk(3, 1, 0, 0), 1'b1);
      wait_done();
      repeat (2) @(negedge clk);

      // Abort in vector 5's settle window; nothing is expected from this sweep.
      mode = 2;
      issue(mk(0, 0, 0, 0), 1'b0);
      for (int i = 0; i < 100 && dut_in != 3'd5; i++) @(negedge clk);
      check("reached_vec5", 32'(dut_in), 32'd5);
      check("err_before_abort", 32'(err_count), 32'd2);
      #2 rst = 1'b1;
      #1 check_all_zero("abort");
      @(negedge clk);
      rst = 1'b0;
      mode = 0;
      issue(mk(0, 0, 0, 1), 1'b1);
      wait_done();
      repeat (2) @(negedge clk);

      // Start pulses mid-sweep must be ignored.
      mode = 1;
      issue(mk(1, 1, 3, 0), 1'b1);
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (2) @(negedge clk);

      // Restart from DONE clears results and repeats them.
      issue(mk(1, 1, 3, 0), 1'b1);
      check("restart_done_low", 32'(done), 32'd0);
      check("restart_err_clear", 32'(err_count), 32'd0);
      check("restart_fv_clear", 32'(fail_valid), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      wait_done();
      repeat (2) @(negedge clk);

      // Reparameterised instance with AND gate.
      e2 = mk(0, 0, 0, 1);
      @(negedge clk);
      start2 = 1'b1;
      e2.done_edge = cyc + 1 + 8;
      q2.push_back(e2);
      @(negedge clk);
      start2 = 1'b0;
      for (int i = 0; i < 100 && !done2; i++) @(negedge clk);
      if (!done2) check("done2_timeout", 32'd0, 32'd1);
      repeat (2) @(negedge clk);

      check("q1_drained", 32'(q1.size()), 32'd0);
      check("q2_drained", 32'(q2.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
